// File: rtl/fpu_pkg.sv
// Shared FPU definitions: fflag bit indices, writeback entry layout and FP opcode encodings.
package fpu_pkg;

   localparam int FFLAG_NV = 4;
   localparam int FFLAG_DZ = 3;
   localparam int FFLAG_OF = 2;
   localparam int FFLAG_UF = 1;
   localparam int FFLAG_NX = 0;

   localparam int WB_ENTRY_W     = 43;
   localparam int ENT_FFLAGS_LSB = 0;
   localparam int ENT_RESULT_LSB = 5;
   localparam int ENT_TO_INT_BIT = 37;
   localparam int ENT_RD_LSB     = 38;

   // Field order matches the offsets above: rd is the MSB field, fflags the LSB field.
   typedef struct packed {
      logic [4:0]  rd;
      logic        to_int;
      logic [31:0] result;
      logic [4:0]  fflags;
   } wb_entry_t;

   typedef enum logic [4:0] {
      FOP_FADD     = 5'd0,
      FOP_FSUB     = 5'd1,
      FOP_FMUL     = 5'd2,
      FOP_FDIV     = 5'd3,
      FOP_FSQRT    = 5'd4,
      FOP_FSGNJ    = 5'd5,
      FOP_FMINMAX  = 5'd6,
      FOP_FEQ      = 5'd7,
      FOP_FLT      = 5'd8,
      FOP_FLE      = 5'd9,
      FOP_FCLASS   = 5'd10,
      FOP_FCVT_W_S = 5'd11,
      FOP_FCVT_S_W = 5'd12,
      FOP_FMV_X_W  = 5'd13,
      FOP_FMV_W_X  = 5'd14,
      FOP_FMADD    = 5'd15
   } fp_op_e;

   function automatic logic fp_op_to_int(input fp_op_e op);
      return op inside {FOP_FEQ, FOP_FLT, FOP_FLE, FOP_FCLASS, FOP_FCVT_W_S, FOP_FMV_X_W};
   endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Generic synchronous FIFO: registered occupancy, head data visible combinationally.
// Push while full and pop while empty are ignored.
module fp_wb_fifo #(
   parameter int WIDTH = 43,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_dat_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_dat_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o     = (count_q == CNT_MAX);
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign head_dat_o = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat_i;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fp_writeback_stage.sv
// FP writeback: in-order FIFO retiring to the FP regfile or the shared int WB port, sticky fflags.
// 1-cycle latency (0 with FP_WB_BYPASS_EN); ready_o = !full, integer heads stall on int_wb_ready_i.
module fp_writeback_stage #(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [4:0]             rd_i,
   input  logic                   to_int_i,
   input  logic [31:0]            result_i,
   input  logic [4:0]             fflags_i,
   output logic                   frf_we_o,
   output logic [4:0]             frf_waddr_o,
   output logic [31:0]            frf_wdata_o,
   output logic                   int_wb_valid_o,
   input  logic                   int_wb_ready_i,
   output logic [4:0]             int_wb_addr_o,
   output logic [31:0]            int_wb_data_o,
   input  logic                   fflags_clr_i,
   output logic [4:0]             fflags_o,
   output logic [$clog2(DEPTH):0] count_o
);

   import fpu_pkg::*;

   wb_entry_t             in_ent;
   wb_entry_t             head_ent;
   wb_entry_t             src_ent;
   logic [WB_ENTRY_W-1:0] head_dat;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic                  src_vld, src_fire, int_need, bypass;
   logic                  frf_sel, int_sel;
   logic [4:0]            fflags_q, fflags_d;

   assign in_ent   = '{rd: rd_i, to_int: to_int_i, result: result_i, fflags: fflags_i};
   assign head_ent = wb_entry_t'(head_dat);
   assign ready_o  = !fifo_full;
   assign fflags_o = fflags_q;

   always_comb begin
`ifdef FP_WB_BYPASS_EN
      // With an empty FIFO the incoming result is the retire candidate.
      src_vld = !fifo_empty || valid_i;
      src_ent = fifo_empty ? in_ent : head_ent;
`else
      src_vld = !fifo_empty;
      src_ent = head_ent;
`endif
      int_need  = src_ent.to_int && (src_ent.rd != 5'd0);
      src_fire  = src_vld && (!int_need || int_wb_ready_i);
      bypass    = src_fire && fifo_empty;
      fifo_pop  = src_fire && !fifo_empty;
      fifo_push = valid_i && ready_o && !bypass;

      frf_sel        = src_vld && !src_ent.to_int;
      int_sel        = src_vld && int_need;
      frf_we_o       = frf_sel;
      int_wb_valid_o = int_sel;
      frf_waddr_o    = '0;
      frf_wdata_o    = '0;
      int_wb_addr_o  = '0;
      int_wb_data_o  = '0;
      if (frf_sel) begin
         frf_waddr_o = src_ent.rd;
         frf_wdata_o = src_ent.result;
      end
      if (int_sel) begin
         int_wb_addr_o = src_ent.rd;
         int_wb_data_o = src_ent.result;
      end

      // Clear lands first so the retiring op's flags survive a coincident CSR write.
      fflags_d = fflags_clr_i ? 5'd0 : fflags_q;
      if (src_fire) begin
         fflags_d = fflags_d | src_ent.fflags;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fflags_q <= '0;
      end else begin
         fflags_q <= fflags_d;
      end
   end

   fp_wb_fifo #(
      .WIDTH (WB_ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (fifo_push),
      .push_dat_i (in_ent),
      .pop_i      (fifo_pop),
      .head_dat_o (head_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (count_o)
   );

endmodule

// File: tb/tb_fp_writeback_stage.sv
// Bench for fp_writeback_stage (default build): queue-based reference model checked every cycle
// plus hand-computed directed expectations.
module tb_fp_writeback_stage;

   localparam int DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [4:0]  rd_i = '0;
   logic        to_int_i = 1'b0;
   logic [31:0] result_i = '0;
   logic [4:0]  fflags_i = '0;
   logic        frf_we_o;
   logic [4:0]  frf_waddr_o;
   logic [31:0] frf_wdata_o;
   logic        int_wb_valid_o;
   logic        int_wb_ready_i = 1'b0;
   logic [4:0]  int_wb_addr_o;
   logic [31:0] int_wb_data_o;
   logic        fflags_clr_i = 1'b0;
   logic [4:0]  fflags_o;
   logic [2:0]  count_o;

   fp_writeback_stage #(.DEPTH(DEPTH)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .rd_i           (rd_i),
      .to_int_i       (to_int_i),
      .result_i       (result_i),
      .fflags_i       (fflags_i),
      .frf_we_o       (frf_we_o),
      .frf_waddr_o    (frf_waddr_o),
      .frf_wdata_o    (frf_wdata_o),
      .int_wb_valid_o (int_wb_valid_o),
      .int_wb_ready_i (int_wb_ready_i),
      .int_wb_addr_o  (int_wb_addr_o),
      .int_wb_data_o  (int_wb_data_o),
      .fflags_clr_i   (fflags_clr_i),
      .fflags_o       (fflags_o),
      .count_o        (count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0]  rd;
      logic        to_int;
      logic [31:0] res;
      logic [4:0]  ff;
   } ment_t;

   ment_t      mq[$];
   logic [4:0] mflags = '0;
   int         n_total = 0;
   int         n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: queue of pending results, retire rules applied to the oldest one.
   always @(posedge clk_i or posedge rst_i) begin : model
      logic  pop;
      logic  push;
      ment_t h;
      ment_t n;
      if (rst_i) begin
         mq.delete();
         mflags = '0;
      end else begin
         pop  = 1'b0;
         push = valid_i && (mq.size() < DEPTH);
         if (mq.size() > 0) begin
            h   = mq[0];
            pop = !h.to_int || (h.rd == 5'd0) || int_wb_ready_i;
         end
         if (fflags_clr_i) mflags = '0;
         if (pop) begin
            mflags = mflags | h.ff;
            void'(mq.pop_front());
         end
         if (push) begin
            n.rd = rd_i; n.to_int = to_int_i; n.res = result_i; n.ff = fflags_i;
            mq.push_back(n);
         end
      end
   end

   always @(negedge clk_i) begin : cmp
      ment_t h;
      logic  ef;
      logic  ei;
      if (!rst_i) begin
         ef = 1'b0;
         ei = 1'b0;
         if (mq.size() > 0) begin
            h  = mq[0];
            ef = !h.to_int;
            ei = h.to_int && (h.rd != 5'd0);
         end
         chk("ready_o", 32'(ready_o), 32'(mq.size() < DEPTH));
         chk("count_o", 32'(count_o), 32'(mq.size()));
         chk("fflags_o", 32'(fflags_o), 32'(mflags));
         chk("frf_we_o", 32'(frf_we_o), 32'(ef));
         chk("int_wb_valid_o", 32'(int_wb_valid_o), 32'(ei));
         if (ef) begin
            chk("frf_waddr_o", 32'(frf_waddr_o), 32'(h.rd));
            chk("frf_wdata_o", frf_wdata_o, h.res);
         end
         if (ei) begin
            chk("int_wb_addr_o", 32'(int_wb_addr_o), 32'(h.rd));
            chk("int_wb_data_o", int_wb_data_o, h.res);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [4:0] rd, input logic ti, input logic [31:0] res,
                       input logic [4:0] ff);
      valid_i  = 1'b1;
      rd_i     = rd;
      to_int_i = ti;
      result_i = res;
      fflags_i = ff;
      step();
      valid_i  = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not finish, checks %0d/%0d", n_pass, n_total);
      $fatal(1, "timeout");
   end

   initial begin
      #1 rst_i = 1'b1;
      #2;
      chk("rst ready_o", 32'(ready_o), 32'd1);
      chk("rst count_o", 32'(count_o), 32'd0);
      chk("rst frf_we_o", 32'(frf_we_o), 32'd0);
      chk("rst int_wb_valid_o", 32'(int_wb_valid_o), 32'd0);
      chk("rst fflags_o", 32'(fflags_o), 32'd0);
      chk("rst frf_waddr_o", 32'(frf_waddr_o), 32'd0);
      chk("rst int_wb_data_o", int_wb_data_o, 32'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Single FP result: written the cycle after the push.
      push(5'd5, 1'b0, 32'h3F80_0000, 5'h00);
      chk("fp1 frf_we_o", 32'(frf_we_o), 32'd1);
      chk("fp1 frf_waddr_o", 32'(frf_waddr_o), 32'd5);
      chk("fp1 frf_wdata_o", frf_wdata_o, 32'h3F80_0000);
      step();
      chk("fp1 count_o after", 32'(count_o), 32'd0);
      chk("fp1 frf_we_o after", 32'(frf_we_o), 32'd0);

      // Integer head stalls a younger FP entry.
      int_wb_ready_i = 1'b0;
      push(5'd10, 1'b1, 32'h0000_0001, 5'h00);
      chk("stall int_wb_valid_o c1", 32'(int_wb_valid_o), 32'd1);
      push(5'd7, 1'b0, 32'h4000_0000, 5'h00);
      chk("stall int_wb_addr_o c2", 32'(int_wb_addr_o), 32'd10);
      chk("stall int_wb_data_o c2", int_wb_data_o, 32'd1);
      chk("stall frf_we_o c2", 32'(frf_we_o), 32'd0);
      chk("stall count_o c2", 32'(count_o), 32'd2);
      step();
      chk("stall int_wb_addr_o c3", 32'(int_wb_addr_o), 32'd10);
      chk("stall frf_we_o c3", 32'(frf_we_o), 32'd0);
      int_wb_ready_i = 1'b1;
      step();
      int_wb_ready_i = 1'b0;
      chk("stall younger frf_we_o", 32'(frf_we_o), 32'd1);
      chk("stall younger frf_waddr_o", 32'(frf_waddr_o), 32'd7);
      chk("stall int_wb_valid_o after", 32'(int_wb_valid_o), 32'd0);
      chk("stall count_o after pop", 32'(count_o), 32'd1);
      step();

      // Fill to full, drop a fifth push, drain in order.
      for (int i = 1; i <= 4; i++) push(5'(i), 1'b1, 32'(i), 5'h00);
      chk("full count_o", 32'(count_o), 32'd4);
      chk("full ready_o", 32'(ready_o), 32'd0);
      push(5'd5, 1'b1, 32'd5, 5'h00);
      chk("full dropped count_o", 32'(count_o), 32'd4);
      chk("model full size", 32'(mq.size()), 32'd4);
      int_wb_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain int_wb_addr_o", 32'(int_wb_addr_o), 32'(i));
         chk("drain int_wb_data_o", int_wb_data_o, 32'(i));
         step();
      end
      int_wb_ready_i = 1'b0;
      chk("drain count_o", 32'(count_o), 32'd0);
      chk("drain int_wb_valid_o", 32'(int_wb_valid_o), 32'd0);

      // Sticky fflags and clear coincident with a pop.
      push(5'd1, 1'b0, 32'h1111_1111, 5'h01);
      push(5'd2, 1'b0, 32'h2222_2222, 5'h05);
      step();
      chk("ff accumulate", 32'(fflags_o), 32'h05);
      chk("model ff accumulate", 32'(mflags), 32'h05);
      push(5'd3, 1'b0, 32'h3333_3333, 5'h08);
      fflags_clr_i = 1'b1;
      step();
      chk("ff clear with pop", 32'(fflags_o), 32'h08);
      chk("model ff clear with pop", 32'(mflags), 32'h08);
      step();
      fflags_clr_i = 1'b0;
      chk("ff clear no pop", 32'(fflags_o), 32'h00);

      // Integer result to x0: silent retire, flags still recorded.
      push(5'd0, 1'b1, 32'hDEAD_BEEF, 5'h10);
      chk("x0 int_wb_valid_o", 32'(int_wb_valid_o), 32'd0);
      chk("x0 frf_we_o", 32'(frf_we_o), 32'd0);
      chk("x0 count_o", 32'(count_o), 32'd1);
      step();
      chk("x0 count_o after", 32'(count_o), 32'd0);
      chk("x0 fflags_o", 32'(fflags_o), 32'h10);

      // Mixed stream with back-to-back pushes and intermittent port grants.
      for (int i = 0; i < 24; i++) begin
         valid_i        = (i % 3) != 2;
         rd_i           = 5'(i % 6);
         to_int_i       = (i % 3) == 0;
         result_i       = 32'h1000_0000 + 32'(i);
         fflags_i       = 5'(1 << (i % 5));
         int_wb_ready_i = ((i % 5) != 0) && ((i % 7) != 3);
         fflags_clr_i   = (i == 13);
         step();
      end
      valid_i        = 1'b0;
      fflags_clr_i   = 1'b0;
      int_wb_ready_i = 1'b1;
      repeat (6) step();
      int_wb_ready_i = 1'b0;

      // Asynchronous reset with three integer entries queued.
      for (int i = 0; i < 3; i++) push(5'(11 + i), 1'b1, 32'hA000_0000 + 32'(i), 5'h02);
      chk("pre-rst count_o", 32'(count_o), 32'd3);
      chk("pre-rst int_wb_valid_o", 32'(int_wb_valid_o), 32'd1);
      #2 rst_i = 1'b1;
      #1;
      chk("arst count_o", 32'(count_o), 32'd0);
      chk("arst int_wb_valid_o", 32'(int_wb_valid_o), 32'd0);
      chk("arst int_wb_addr_o", 32'(int_wb_addr_o), 32'd0);
      chk("arst int_wb_data_o", int_wb_data_o, 32'd0);
      chk("arst fflags_o", 32'(fflags_o), 32'd0);
      chk("arst ready_o", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      int_wb_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post-rst count_o", 32'(count_o), 32'd0);
         chk("post-rst int_wb_valid_o", 32'(int_wb_valid_o), 32'd0);
         chk("post-rst frf_we_o", 32'(frf_we_o), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
